// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encoding, status flags and
// frame-length helpers used by the FSM and by the combinational core.
package SerialAluPkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SLT = 3'd5,
        SLL = 3'd6,
        SRL = 3'd7
    } AluOp;

    typedef struct packed {
        logic carry;
        logic zero;
    } AluStatus;

    function automatic int request_bits(input int width);
        return OP_W + 2 * width;
    endfunction

    function automatic int response_bits(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/serial_alu_core.sv
// Combinational ALU datapath: op_code/op_1/op_2 in, result and flags out.
// Shifts use only the low clog2(DATA_WIDTH) bits of op_2 as the amount.
module alu_core
    import SerialAluPkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [OP_W-1:0]       op_code,
    input  logic [DATA_WIDTH-1:0] op_1,
    input  logic [DATA_WIDTH-1:0] op_2,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  zero
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH:0] sum;
    logic [SH_W-1:0]     shift_amt;
    logic                less_signed;

    assign sum         = {1'b0, op_1} + {1'b0, op_2};
    assign shift_amt   = op_2[SH_W-1:0];
    assign less_signed = $signed(op_1) < $signed(op_2);

    // Select the operation; carry is only meaningful for ADD and SUB
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (AluOp'(op_code))
            ADD: begin
                result = sum[DATA_WIDTH-1:0];
                carry  = sum[DATA_WIDTH];
            end
            SUB: begin
                result = op_1 - op_2;
                carry  = (op_1 >= op_2);
            end
            AND: result = op_1 & op_2;
            OR:  result = op_1 | op_2;
            XOR: result = op_1 ^ op_2;
            SLT: result = {{(DATA_WIDTH-1){1'b0}}, less_signed};
            SLL: result = op_1 << shift_amt;
            SRL: result = op_1 >> shift_amt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU slave. Collects op_code, op_1, op_2 one bit at a time,
// evaluates in one EXEC cycle, then streams back result, carry and zero.
// Define SERIAL_ALU_PARITY_EN to append an even-parity bit to the response.
module serial_alu
    import SerialAluPkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_bit,
    input  logic in_sof,
    input  logic in_valid,
    output logic in_ready,
    output logic out_bit,
    output logic out_last,
    output logic out_valid,
    input  logic out_ready,
    output logic busy
);

`ifdef SERIAL_ALU_PARITY_EN
    localparam int RESP_W = response_bits(DATA_WIDTH) + 1;
`else
    localparam int RESP_W = response_bits(DATA_WIDTH);
`endif
    localparam int CNT_W = $clog2(DATA_WIDTH + 3);

    localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] ST_RX_OP = 3'd0;
    localparam logic [2:0] ST_RX_A  = 3'd1;
    localparam logic [2:0] ST_RX_B  = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_TX    = 3'd4;

    logic [2:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [OP_W-1:0]       op_code;
    logic [DATA_WIDTH-1:0] op_1;
    logic [DATA_WIDTH-1:0] op_2;
    logic [RESP_W-1:0]     tx_shift;

    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] ordered_result;
    AluStatus              alu_status;
    logic [RESP_W-1:0]     resp_word;
    logic                  in_accept;
    logic                  out_accept;

    alu_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu_core (
        .op_code(op_code),
        .op_1   (op_1),
        .op_2   (op_2),
        .result (alu_result),
        .carry  (alu_status.carry),
        .zero   (alu_status.zero)
    );

    assign in_ready   = (state == ST_RX_OP) || (state == ST_RX_A) || (state == ST_RX_B);
    assign out_valid  = (state == ST_TX);
    assign out_bit    = out_valid & tx_shift[0];
    assign out_last   = out_valid && (bit_cnt == RESP_LAST);
    assign busy       = !((state == ST_RX_OP) && (bit_cnt == '0));
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;

    // Put result bits in transmit order so bit 0 of the word always goes out first
    always_comb begin
        ordered_result = alu_result;
        if (MSB_FIRST) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                ordered_result[i] = alu_result[DATA_WIDTH-1-i];
            end
        end
    end

`ifdef SERIAL_ALU_PARITY_EN
    assign resp_word = {(^alu_result) ^ alu_status.carry ^ alu_status.zero,
                        alu_status.zero, alu_status.carry, ordered_result};
`else
    assign resp_word = {alu_status.zero, alu_status.carry, ordered_result};
`endif

    // Frame FSM: receive fields, execute once, shift out the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RX_OP;
            bit_cnt  <= '0;
            op_code  <= '0;
            op_1     <= '0;
            op_2     <= '0;
            tx_shift <= '0;
        end else begin
            case (state)
                ST_RX_OP, ST_RX_A, ST_RX_B: begin
                    if (in_accept) begin
                        if (in_sof) begin
                            op_code <= MSB_FIRST ? {op_code[OP_W-2:0], in_bit}
                                                 : {in_bit, op_code[OP_W-1:1]};
                            bit_cnt <= CNT_ONE;
                            state   <= ST_RX_OP;
                        end else if (state == ST_RX_OP) begin
                            if (bit_cnt != '0) begin
                                op_code <= MSB_FIRST ? {op_code[OP_W-2:0], in_bit}
                                                     : {in_bit, op_code[OP_W-1:1]};
                                if (bit_cnt == OP_LAST) begin
                                    bit_cnt <= '0;
                                    state   <= ST_RX_A;
                                end else begin
                                    bit_cnt <= bit_cnt + CNT_ONE;
                                end
                            end
                        end else if (state == ST_RX_A) begin
                            op_1 <= MSB_FIRST ? {op_1[DATA_WIDTH-2:0], in_bit}
                                              : {in_bit, op_1[DATA_WIDTH-1:1]};
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                state   <= ST_RX_B;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_ONE;
                            end
                        end else begin
                            op_2 <= MSB_FIRST ? {op_2[DATA_WIDTH-2:0], in_bit}
                                              : {in_bit, op_2[DATA_WIDTH-1:1]};
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                state   <= ST_EXEC;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_ONE;
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    tx_shift <= resp_word;
                    bit_cnt  <= '0;
                    state    <= ST_TX;
                end
                ST_TX: begin
                    if (out_accept) begin
                        tx_shift <= {1'b0, tx_shift[RESP_W-1:1]};
                        if (bit_cnt == RESP_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_RX_OP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    state   <= ST_RX_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (DATA_WIDTH=8, LSB first).
// Expected responses come from an integer-arithmetic model of the ALU ops.
module tb_serial_alu;

    localparam int DW = 8;
`ifdef SERIAL_ALU_PARITY_EN
    localparam int RESP_W = DW + 3;
`else
    localparam int RESP_W = DW + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_bit = 1'b0;
    logic in_sof = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready;
    logic out_bit;
    logic out_last;
    logic out_valid;
    logic busy;

    int total = 0;
    int bad = 0;

    serial_alu #(
        .DATA_WIDTH(DW),
        .MSB_FIRST (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bit   (in_bit),
        .in_sof   (in_sof),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_bit  (out_bit),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends even if a task wedges
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Integer model of the eight operations on 8-bit operands
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output bit c, output bit z);
        int sa;
        int sb;
        c = 1'b0;
        case (op)
            0: begin res = (a + b) % 256; c = (a + b) > 255; end
            1: begin res = (a - b + 256) % 256; c = (a >= b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin
                sa  = (a > 127) ? a - 256 : a;
                sb  = (b > 127) ? b - 256 : b;
                res = (sa < sb) ? 1 : 0;
            end
            6: res = (a * (2 ** (b % 8))) % 256;
            default: res = a / (2 ** (b % 8));
        endcase
        z = (res == 0);
    endfunction

    task automatic checkReset(input string tag);
        compare({tag, ":in_ready"}, in_ready, 1);
        compare({tag, ":out_valid"}, out_valid, 0);
        compare({tag, ":out_last"}, out_last, 0);
        compare({tag, ":out_bit"}, out_bit, 0);
        compare({tag, ":busy"}, busy, 0);
    endtask

    // Drive the first nbits of a request frame, in_sof on the first bit
    task automatic applyStimulus(input int op, input int a, input int b, input int nbits);
        logic [2*DW+2:0] frame;
        logic [2:0]      op_bits;
        logic [DW-1:0]   a_bits;
        logic [DW-1:0]   b_bits;
        op_bits = op[2:0];
        a_bits  = a[DW-1:0];
        b_bits  = b[DW-1:0];
        frame   = {b_bits, a_bits, op_bits};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            compare("rx_in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_bit   = frame[i];
            in_sof   = (i == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_bit   = 1'b0;
    endtask

    // Collect one response (entered in the EXEC cycle) and compare with the model
    task automatic checkOutput(input string tag, input int op, input int a, input int b,
                               input int stall_at, input int stall_len);
        int              exp_res;
        bit              exp_c;
        bit              exp_z;
        logic [7:0]      er;
        logic [RESP_W-1:0] got_bits;
        logic            hold;
        int              got;
        int              cycles;
        model(op, a, b, exp_res, exp_c, exp_z);
        er       = exp_res[7:0];
        got_bits = '0;
        got      = 0;
        cycles   = 0;
        compare({tag, ":exec_out_valid"}, out_valid, 0);
        compare({tag, ":exec_in_ready"}, in_ready, 0);
        out_ready = 1'b1;
        while (got < RESP_W && cycles < 64) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) compare({tag, ":first_valid"}, out_valid, 1);
            if (out_valid) begin
                if (got == stall_at && stall_len > 0) begin
                    out_ready = 1'b0;
                    hold = out_bit;
                    repeat (stall_len) begin
                        @(negedge clk);
                        cycles++;
                        compare({tag, ":stall_bit"}, out_bit, hold);
                        compare({tag, ":stall_in_ready"}, in_ready, 0);
                    end
                    out_ready = 1'b1;
                end
                compare({tag, ":tx_in_ready"}, in_ready, 0);
                compare({tag, ":out_last"}, out_last, (got == RESP_W - 1));
                got_bits[got] = out_bit;
                got++;
            end
        end
        compare({tag, ":bit_count"}, got, RESP_W);
        compare({tag, ":result"}, got_bits[DW-1:0], er);
        compare({tag, ":carry"}, got_bits[DW], exp_c);
        compare({tag, ":zero"}, got_bits[DW+1], exp_z);
`ifdef SERIAL_ALU_PARITY_EN
        compare({tag, ":parity"}, got_bits[DW+2], (^er) ^ exp_c ^ exp_z);
`endif
        @(negedge clk);
        compare({tag, ":idle_out_valid"}, out_valid, 0);
        compare({tag, ":idle_busy"}, busy, 0);
    endtask

    initial begin
        int op;
        int a;
        int b;
        $display("[TB] start, response width %0d", RESP_W);

        #2;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 8'hF0, 8'h20, 19);
        checkOutput("add", 0, 8'hF0, 8'h20, -1, 0);
        applyStimulus(1, 8'h05, 8'h05, 19);
        checkOutput("sub_eq", 1, 8'h05, 8'h05, -1, 0);
        applyStimulus(1, 8'h03, 8'h04, 19);
        checkOutput("sub_borrow", 1, 8'h03, 8'h04, -1, 0);
        applyStimulus(5, 8'h80, 8'h01, 19);
        checkOutput("slt", 5, 8'h80, 8'h01, -1, 0);
        applyStimulus(6, 8'h01, 8'hF3, 19);
        checkOutput("sll", 6, 8'h01, 8'hF3, -1, 0);
        applyStimulus(7, 8'h80, 8'h07, 19);
        checkOutput("srl", 7, 8'h80, 8'h07, -1, 0);

        applyStimulus(3, 8'h5A, 8'h3C, 19);
        checkOutput("stall", 3, 8'h5A, 8'h3C, 4, 5);

        applyStimulus(0, 8'h11, 8'h22, 9);
        applyStimulus(4, 8'hAA, 8'h0F, 19);
        checkOutput("resync_xor", 4, 8'hAA, 8'h0F, -1, 0);
        repeat (4) begin
            @(negedge clk);
            compare("resync_single", out_valid, 0);
        end

        applyStimulus(0, 8'h33, 8'h44, 14);
        compare("rx_b_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkReset("reset_rx_b");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3, 8'hC0, 8'h03, 19);
        checkOutput("after_rx_b_reset", 3, 8'hC0, 8'h03, -1, 0);

        applyStimulus(2, 8'hFF, 8'h0F, 19);
        out_ready = 1'b0;
        @(negedge clk);
        compare("tx_before_reset", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkReset("reset_tx");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            compare("no_partial_resp", out_valid, 0);
        end
        applyStimulus(1, 8'h10, 8'h01, 19);
        checkOutput("after_tx_reset", 1, 8'h10, 8'h01, -1, 0);

        applyStimulus(0, 8'h01, 8'h00, 19);
        checkOutput("add_parity", 0, 8'h01, 8'h00, -1, 0);

        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            applyStimulus(op, a, b, 19);
            checkOutput("random", op, a, b, $urandom_range(0, RESP_W - 1), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Bit-serial ALU slave for the mini serial processor, generalised in operand width (DATA_WIDTH) and extended to an 8-operation set with status flags.
- Receives one request frame bit by bit: op_code, then op_1, then op_2.
- Computes in a single cycle, then returns a response frame: result, carry, zero.
- Sits between the processor's serialiser and its register write-back path.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; legal values are powers of two from 4 to 64.
- MSB_FIRST, 0, bit order of each field on both streams; 0 = LSB first, 1 = MSB first; op_code is always the first field.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_bit  input  1  serial request data.
- in_sof  input  1  marks first bit of a request frame; qualified by in_valid.
- in_valid  input  1  in_bit is valid.
- in_ready  output  1  block accepts in_bit this cycle.
- out_bit  output  1  serial response data.
- out_last  output  1  marks final bit of the response frame.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  consumer accepts out_bit this cycle.
- busy  output  1  high in every state except RX_OP with bit counter 0.

Behaviour:
- Handshakes: input bit transfers when in_valid && in_ready; output bit transfers when out_valid && out_ready.
- Request frame: OP_W=3 bits op_code, then DATA_WIDTH bits op_1, then DATA_WIDTH bits op_2; total 3+2*DATA_WIDTH bits.
- Response frame: DATA_WIDTH result bits, then carry, then zero; total DATA_WIDTH+2 bits (+1 with option).
- FSM states: RX_OP, RX_A, RX_B, EXEC, TX. One bit counter, width clog2(DATA_WIDTH+3).
- RX_OP/RX_A/RX_B: in_ready=1. Shift the accepted bit into the field register; advance state when the field count completes.
- Bits accepted in RX_OP at count 0 with in_sof=0 are discarded; the counter stays 0 (resynchronisation).
- in_sof=1 on any accepted bit in RX_OP/RX_A/RX_B: that bit becomes op_code bit 0 and the partial frame is discarded.
- EXEC: exactly 1 cycle, in_ready=0. Registers result and flags, loads the TX shift register, goes to TX.
- TX: out_valid=1, starting the cycle after EXEC (first output bit 1 cycle after the last input bit).
  - Each accepted bit advances the shift register; out_last=1 on the final bit.
  - When the last bit is accepted, go to RX_OP.
  - in_ready=0 throughout TX; out_bit is held stable while out_ready=0.
- Operations (AluOp): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7.
  - ADD: result = op_1+op_2, wrapping; carry = unsigned carry-out.
  - SUB: result = op_1-op_2, wrapping; carry = 1 when op_1 >= op_2 unsigned (no borrow).
  - SLT: signed compare; result = 1 when op_1 < op_2, else 0.
  - SLL/SRL: shift amount = op_2[clog2(DATA_WIDTH)-1:0]; upper bits of op_2 are ignored; SRL is logical.
  - carry = 0 for every op other than ADD and SUB.
  - zero = (result == 0) for every op.
- Reset (asynchronous, any state): state=RX_OP, counter=0, all data registers 0, in_ready=1, out_valid=0, out_last=0, out_bit=0, busy=0.
  - A frame interrupted by reset is lost; no partial response is emitted.

Optional Feature:
- Macro SERIAL_ALU_PARITY_EN.
- Defined: one extra bit is appended after zero, equal to even parity (XOR) over result, carry and zero. out_last moves to this bit; response is DATA_WIDTH+3 bits.
- Undefined: response is DATA_WIDTH+2 bits and no parity logic exists.

Decomposition:
- Package SerialAluPkg holds:
  - OP_W=3.
  - AluOp enum.
  - Function request_bits(width) = 3+2*width.
  - Function response_bits(width) = width+2.
  - Packed struct AluStatus {carry, zero}.
- Sub-module alu_core: purely combinational op_code/op_1/op_2 -> result, carry, zero, instantiated once. The FSM and shift registers stay in serial_alu.

Test Plan (DATA_WIDTH=8, MSB_FIRST=0):
- ADD 0xF0+0x20 -> result 0x10, carry=1, zero=0; out_valid the cycle after EXEC; out_last on bit 9.
- SUB 0x05-0x05 -> result 0x00, carry=1, zero=1. SUB 0x03-0x04 -> 0xFF, carry=0.
- SLT 0x80 vs 0x01 -> 0x01; SLL 0x01 by op_2=0xF3 -> 0x08; SRL 0x80 by 7 -> 0x01.
- out_ready held low 5 cycles mid-response -> out_bit stable and no bit lost; in_ready=0 throughout TX.
- in_sof reasserted after 6 op_1 bits, then a full XOR 0xAA^0x0F frame -> exactly one response, 0xA5.
- rst_n pulsed low during RX_B and during TX -> outputs return to reset values immediately; the next frame is processed correctly. Parity build: ADD 0x01+0x00 -> parity bit 1.
